// File: rtl/uart_cmd_rx_if.sv
// Purpose: serial line in, received byte and command status/control levels out.
// Latency: carries no logic, so it adds no delay.
// Backpressure: none. Every output is a pulse or a level, so nothing waits on a consumer.
// Port summary:
//   uart_rx   serial line, idle high
//   rx_data   last received byte
//   rx_valid  one-cycle byte strobe
//   frame_err one-cycle bad-stop strobe
//   cmd_valid one-cycle applied-command strobe
//   cmd_err   one-cycle aborted-command strobe
//   fir_en, lms_en, pmod_sel  control levels
interface uart_cmd_rx_if;
   logic       uart_rx;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       frame_err;
   logic       cmd_valid;
   logic       cmd_err;
   logic       fir_en;
   logic       lms_en;
   logic       pmod_sel;

   // master: the receiver, which drives the status and control outputs
   modport master (
      input  uart_rx,
      output rx_data, rx_valid, frame_err, cmd_valid, cmd_err,
             fir_en, lms_en, pmod_sel
   );

   // slave: the line source and the consumer of the outputs
   modport slave (
      output uart_rx,
      input  rx_data, rx_valid, frame_err, cmd_valid, cmd_err,
             fir_en, lms_en, pmod_sel
   );
endinterface

// File: rtl/uart_cmd_rx.sv
// Purpose: 8N1 UART receiver feeding a 3-byte command parser ("F|L|P", "0|1", LF).
// Latency: rx_valid appears 1 clock after the stop-bit mid-sample; the control output changes 1 clock later.
// Backpressure: none. Every output is a pulse or a level, and received bytes are never held off.
// Ports: sys_clk, sys_rst (synchronous, active-high); bus = uart_cmd_rx_if.master.
module uart_cmd_rx #(
   parameter int CLK_FREQ = 50_000_000,
   parameter int BAUD     = 115200,
   parameter int TIMEOUT  = 5_000_000
) (
   input  logic          sys_clk,
   input  logic          sys_rst,
   uart_cmd_rx_if.master bus
);
   localparam int BIT_CNT = CLK_FREQ / BAUD;
   localparam int CW      = $clog2(BIT_CNT);
   localparam int TW      = $clog2(TIMEOUT + 1);

   localparam logic [7:0] OP_F = 8'h46, OP_L = 8'h4C, OP_P = 8'h50;
   localparam logic [7:0] CH_0 = 8'h30, CH_1 = 8'h31, CH_LF = 8'h0A;

   // ---------------- receiver ----------------
   typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;
   rx_state_t rx_state, rx_state_n;

   logic          sync1, sync2, rx_prev;
   logic [CW-1:0] cnt, cnt_n;
   logic [2:0]    bit_idx, bit_idx_n;
   logic [7:0]    shift, shift_n;
   logic          byte_ok, byte_bad;
   logic [7:0]    rx_data;
   logic          rx_valid, frame_err;

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         sync1     <= 1'b1;
         sync2     <= 1'b1;
         rx_prev   <= 1'b1;
         rx_state  <= IDLE;
         cnt       <= '0;
         bit_idx   <= '0;
         shift     <= '0;
         rx_data   <= '0;
         rx_valid  <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         sync1     <= bus.uart_rx;
         sync2     <= sync1;
         rx_prev   <= sync2;
         rx_state  <= rx_state_n;
         cnt       <= cnt_n;
         bit_idx   <= bit_idx_n;
         shift     <= shift_n;
         rx_valid  <= byte_ok;
         frame_err <= byte_bad;
         if (byte_ok)
            rx_data <= shift;
      end
   end

   always_comb begin
      rx_state_n = rx_state;
      cnt_n      = cnt + CW'(1);
      bit_idx_n  = bit_idx;
      shift_n    = shift;
      byte_ok    = 1'b0;
      byte_bad   = 1'b0;
      case (rx_state)
         IDLE: begin
            cnt_n = '0;
            if (rx_prev && !sync2)
               rx_state_n = START;
         end
         START: begin
            // A line that is high again at mid start bit was a glitch.
            if (cnt == CW'(BIT_CNT / 2)) begin
               cnt_n      = '0;
               bit_idx_n  = '0;
               rx_state_n = sync2 ? IDLE : DATA;
            end
         end
         DATA: begin
            if (cnt == CW'(BIT_CNT - 1)) begin
               cnt_n   = '0;
               shift_n = {sync2, shift[7:1]};
               if (bit_idx == 3'd7)
                  rx_state_n = STOP;
               else
                  bit_idx_n = bit_idx + 3'd1;
            end
         end
         STOP: begin
            // Go idle at the mid-sample so a start bit that follows with no gap is still caught.
            if (cnt == CW'(BIT_CNT - 1)) begin
               cnt_n      = '0;
               rx_state_n = IDLE;
               byte_ok    = sync2;
               byte_bad   = !sync2;
            end
         end
         default: rx_state_n = IDLE;
      endcase
   end

   // ---------------- command parser ----------------
   typedef enum logic [1:0] {P_OP, P_VAL, P_END} p_state_t;
   p_state_t p_state, p_state_n;

   logic [7:0]    op, op_n;
   logic          val, val_n;
   logic [TW-1:0] tcnt;
   logic          timed_out, cmd_ok, cmd_bad;
   logic          cmd_valid, cmd_err, fir_en, lms_en, pmod_sel;

   assign timed_out = (p_state != P_OP) && (tcnt == TW'(TIMEOUT - 1));

   always_comb begin
      p_state_n = p_state;
      op_n      = op;
      val_n     = val;
      cmd_ok    = 1'b0;
      cmd_bad   = 1'b0;
      if (rx_valid) begin
         case (p_state)
            P_OP: begin
               // Any byte that is not an opcode, including stray CR/LF, is ignored without an error.
               if (rx_data == OP_F || rx_data == OP_L || rx_data == OP_P) begin
                  op_n      = rx_data;
                  p_state_n = P_VAL;
               end
            end
            P_VAL: begin
               if (rx_data == CH_0 || rx_data == CH_1) begin
                  val_n     = rx_data[0];
                  p_state_n = P_END;
               end else begin
                  cmd_bad   = 1'b1;
                  p_state_n = P_OP;
               end
            end
            P_END: begin
               cmd_ok    = (rx_data == CH_LF);
               cmd_bad   = (rx_data != CH_LF);
               p_state_n = P_OP;
            end
            default: p_state_n = P_OP;
         endcase
      end else if ((frame_err || timed_out) && p_state != P_OP) begin
         cmd_bad   = 1'b1;
         p_state_n = P_OP;
      end
   end

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         p_state   <= P_OP;
         op        <= '0;
         val       <= 1'b0;
         tcnt      <= '0;
         cmd_valid <= 1'b0;
         cmd_err   <= 1'b0;
         fir_en    <= 1'b0;
         lms_en    <= 1'b0;
         pmod_sel  <= 1'b0;
      end else begin
         p_state   <= p_state_n;
         op        <= op_n;
         val       <= val_n;
         cmd_valid <= cmd_ok;
         cmd_err   <= cmd_bad;
         // The idle timer runs only while a command is part-way through.
         if (rx_valid || p_state == P_OP)
            tcnt <= '0;
         else
            tcnt <= tcnt + TW'(1);
         if (cmd_ok) begin
            case (op)
               OP_F:    fir_en   <= val;
               OP_L:    lms_en   <= val;
               OP_P:    pmod_sel <= val;
               default: ;
            endcase
         end
      end
   end

   assign bus.rx_data   = rx_data;
   assign bus.rx_valid  = rx_valid;
   assign bus.frame_err = frame_err;
   assign bus.cmd_valid = cmd_valid;
   assign bus.cmd_err   = cmd_err;
   assign bus.fir_en    = fir_en;
   assign bus.lms_en    = lms_en;
   assign bus.pmod_sel  = pmod_sel;
endmodule

// File: tb/tb_uart_cmd_rx.sv
// Purpose: self-checking bench for uart_cmd_rx. It combines directed scenarios with random command traffic.
// Latency: checks run after each frame, once the stop bit has fully elapsed.
// Backpressure: not applicable; the bench drives the serial line directly.
module tb_uart_cmd_rx;
   localparam int CLK_FREQ = 3_200_000;
   localparam int BAUD     = 100_000;
   localparam int TIMEOUT  = 1000;
   localparam int BIT      = CLK_FREQ / BAUD;   // 32 clocks per bit

   logic sys_clk = 1'b0;
   logic sys_rst = 1'b1;
   uart_cmd_rx_if bus ();

   uart_cmd_rx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .TIMEOUT(TIMEOUT)) dut (
      .sys_clk (sys_clk),
      .sys_rst (sys_rst),
      .bus     (bus)
   );

   always #5 sys_clk = ~sys_clk;

   int n_cmp = 0;
   int n_bad = 0;

   // Observed activity, sampled on the falling edge. Pulses are counted as high cycles.
   int       cyc = 0, n_rxv = 0, n_fe = 0, n_cv = 0, n_ce = 0;
   int       rxv_cyc = 0, ctl_cyc = 0;
   logic [2:0] ctl_prev = 3'b000;
   always @(negedge sys_clk) begin
      cyc = cyc + 1;
      if (bus.rx_valid)  begin n_rxv = n_rxv + 1; rxv_cyc = cyc; end
      if (bus.frame_err) n_fe = n_fe + 1;
      if (bus.cmd_valid) n_cv = n_cv + 1;
      if (bus.cmd_err)   n_ce = n_ce + 1;
      if ({bus.fir_en, bus.lms_en, bus.pmod_sel} !== ctl_prev) ctl_cyc = cyc;
      ctl_prev = {bus.fir_en, bus.lms_en, bus.pmod_sel};
   end

   // Reference model: expected event counts and the partial command held as a byte list.
   int         e_rxv = 0, e_fe = 0, e_cv = 0, e_ce = 0;
   logic       m_fir = 0, m_lms = 0, m_pmod = 0;
   logic [7:0] m_last = 8'h00;
   logic [7:0] m_q[$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic model_byte(input logic [7:0] b, input bit ok);
      if (!ok) begin
         e_fe++;
         if (m_q.size() != 0) begin e_ce++; m_q.delete(); end
      end else begin
         e_rxv++;
         m_last = b;
         if (m_q.size() == 0) begin
            if (b == "F" || b == "L" || b == "P") m_q.push_back(b);
         end else if (m_q.size() == 1) begin
            if (b == "0" || b == "1") m_q.push_back(b);
            else begin e_ce++; m_q.delete(); end
         end else begin
            if (b == 8'h0A) begin
               e_cv++;
               case (m_q[0])
                  "F": m_fir  = (m_q[1] == "1");
                  "L": m_lms  = (m_q[1] == "1");
                  default: m_pmod = (m_q[1] == "1");
               endcase
            end else e_ce++;
            m_q.delete();
         end
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin @(posedge sys_clk); #1; end
   endtask

   task automatic send_byte(input logic [7:0] b, input bit ok);
      bus.uart_rx = 1'b0;
      tick(BIT);
      for (int i = 0; i < 8; i++) begin
         bus.uart_rx = b[i];
         tick(BIT);
      end
      bus.uart_rx = ok;
      tick(BIT);
      if (!ok) begin bus.uart_rx = 1'b1; tick(BIT); end
      model_byte(b, ok);
   endtask

   task automatic send_str(input string s);
      for (int i = 0; i < s.len(); i++) send_byte(s[i], 1'b1);
   endtask

   task automatic check_all(input string tag);
      check({tag, ".rx_valid_cnt"},  n_rxv, e_rxv);
      check({tag, ".frame_err_cnt"}, n_fe,  e_fe);
      check({tag, ".cmd_valid_cnt"}, n_cv,  e_cv);
      check({tag, ".cmd_err_cnt"},   n_ce,  e_ce);
      check({tag, ".rx_data"},  bus.rx_data,  m_last);
      check({tag, ".fir_en"},   bus.fir_en,   m_fir);
      check({tag, ".lms_en"},   bus.lms_en,   m_lms);
      check({tag, ".pmod_sel"}, bus.pmod_sel, m_pmod);
   endtask

   task automatic check_rst(input string tag);
      check({tag, ".rx_data"},   bus.rx_data,   8'h00);
      check({tag, ".rx_valid"},  bus.rx_valid,  0);
      check({tag, ".frame_err"}, bus.frame_err, 0);
      check({tag, ".cmd_valid"}, bus.cmd_valid, 0);
      check({tag, ".cmd_err"},   bus.cmd_err,   0);
      check({tag, ".fir_en"},    bus.fir_en,    0);
      check({tag, ".lms_en"},    bus.lms_en,    0);
      check({tag, ".pmod_sel"},  bus.pmod_sel,  0);
   endtask

   initial begin
      logic [7:0] f_byte;
      bus.uart_rx = 1'b1;
      sys_rst = 1'b1;
      tick(5);
      check_rst("reset");
      sys_rst = 1'b0;
      tick(10);

      // Single byte
      send_byte(8'h55, 1'b1);
      check_all("byte55");

      // Two commands back-to-back with no idle time; control follows rx_valid by one clock
      send_str("F1\nP1\n");
      check_all("f1p1");
      check("lf_to_ctl_latency", ctl_cyc - rxv_cyc, 1);

      // Framing error alone, then in the middle of a command
      send_byte(8'hA3, 1'b0);
      check_all("fe_idle");
      send_str("L1");
      send_byte(8'hA3, 1'b0);
      check_all("fe_cmd");

      // Illegal value and illegal terminator, then a good command
      send_str("LX\n");
      send_str("L1A");
      check_all("bad_cmds");
      send_str("L1\n");
      check_all("l1");

      // Idle timeout discards the partial command
      send_str("F0");
      tick(TIMEOUT + 10);
      e_ce++;
      m_q.delete();
      check_all("timeout");
      send_str("\n");
      check_all("after_timeout");

      // Start-bit glitch shorter than half a bit
      bus.uart_rx = 1'b0;
      tick(10);
      bus.uart_rx = 1'b1;
      tick(3 * BIT);
      check_all("glitch");

      // Reset during bit 4 of 'F', with "L0" already pending
      send_str("L0");
      f_byte = "F";
      bus.uart_rx = 1'b0;
      tick(BIT);
      for (int i = 0; i < 4; i++) begin bus.uart_rx = f_byte[i]; tick(BIT); end
      bus.uart_rx = f_byte[4];
      tick(BIT / 2);
      sys_rst = 1'b1;
      bus.uart_rx = 1'b1;
      tick(1);
      check_rst("mid_reset");
      tick(3);
      sys_rst = 1'b0;
      m_fir = 0; m_lms = 0; m_pmod = 0; m_last = 8'h00; m_q.delete();
      tick(4 * BIT);
      check_all("post_reset");
      send_str("0\n");
      send_str("F1\n");
      check_all("post_reset_f1");

      // Random traffic: legal commands, corrupted commands, garbage bytes, framing errors
      for (int it = 0; it < 25; it++) begin
         int kind;
         logic [7:0] ops [3];
         ops[0] = "F"; ops[1] = "L"; ops[2] = "P";
         kind = $urandom_range(0, 9);
         if (kind < 5) begin
            send_byte(ops[$urandom_range(0, 2)], 1'b1);
            tick($urandom_range(0, 40));
            send_byte($urandom_range(0, 1) ? "1" : "0", 1'b1);
            tick($urandom_range(0, 40));
            send_byte(8'h0A, 1'b1);
         end else if (kind < 7) begin
            send_byte(ops[$urandom_range(0, 2)], 1'b1);
            send_byte(8'($urandom_range(0, 255)), 1'b1);
            send_byte(8'($urandom_range(0, 255)), 1'b1);
         end else if (kind < 9) begin
            send_byte(8'($urandom_range(0, 255)), 1'b1);
         end else begin
            send_byte(ops[$urandom_range(0, 2)], 1'b1);
            send_byte(8'($urandom_range(0, 255)), 1'b0);
         end
         tick($urandom_range(0, 40));
         check_all($sformatf("rand%0d", it));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/uart_cmd_rx.md
UART_CMD_RX -- requirements
Module: uart_cmd_rx

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 50_000_000, system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 115200, UART bit rate; BIT_CNT = CLK_FREQ/BAUD (434 at defaults).
REQ-003 SHALL have parameter TIMEOUT, default 5_000_000, idle clocks before a partial command is discarded (100 ms).
REQ-004 sys_clk  input  1  single clock for all logic (50 MHz board clock).
REQ-005 sys_rst  input  1  reset, synchronous to sys_clk, active-high.
REQ-006 uart_rx  input  1  asynchronous serial line from PC, idle high, 8N1.
REQ-007 rx_data  output  8  last received byte.
REQ-008 rx_valid  output  1  one-cycle pulse, rx_data valid.
REQ-009 frame_err  output  1  one-cycle pulse, stop bit sampled low.
REQ-010 cmd_valid  output  1  one-cycle pulse, a complete legal command was applied.
REQ-011 cmd_err  output  1  one-cycle pulse, illegal byte, frame error or timeout aborted a command.
REQ-012 fir_en  output  1  FIR-path enable level.
REQ-013 lms_en  output  1  LMS-start enable level.
REQ-014 pmod_sel  output  1  PMOD output select level (1 = LMS path, 0 = FIR path).

Function
REQ-015 uart_rx SHALL pass through a 2-flop synchronizer; all decisions use the synchronized value.
REQ-016 Receiver FSM SHALL have states IDLE, START, DATA, STOP; bit counter counts 0..BIT_CNT-1.
REQ-017 IDLE -> START on synchronized high-to-low transition; START samples at count BIT_CNT/2: low -> DATA, high -> IDLE (glitch, no pulse).
REQ-018 DATA SHALL sample 8 bits each BIT_CNT clocks after the start-bit sample, LSB first.
REQ-019 STOP SHALL sample BIT_CNT clocks after bit 7: high -> rx_data updated and rx_valid pulsed next cycle; low -> frame_err pulsed, rx_data unchanged; both -> IDLE.
REQ-020 Return to IDLE at stop-bit mid-sample SHALL allow back-to-back frames with zero idle time.
REQ-021 Command format: 3 bytes: opcode ('F'=0x46, 'L'=0x4C, 'P'=0x50), value ('0'=0x30 or '1'=0x31), terminator LF (0x0A).
REQ-022 Parser FSM SHALL have states P_OP, P_VAL, P_END, advancing only on rx_valid.
REQ-023 P_OP: legal opcode -> latch opcode, P_VAL; any other byte (including LF, CR) -> stay P_OP silently, no cmd_err.
REQ-024 P_VAL: '0'/'1' -> latch value, P_END; otherwise cmd_err, -> P_OP.
REQ-025 P_END: LF -> target register loaded with value and cmd_valid pulsed in the cycle after rx_valid, -> P_OP; otherwise cmd_err, -> P_OP.
REQ-026 Opcode mapping: 'F' -> fir_en, 'L' -> lms_en, 'P' -> pmod_sel; other control outputs unchanged.
REQ-027 frame_err while in P_VAL or P_END SHALL pulse cmd_err and return to P_OP; in P_OP no cmd_err.
REQ-028 Timeout counter SHALL clear on every rx_valid, count while in P_VAL/P_END; reaching TIMEOUT -> cmd_err pulse, -> P_OP.
REQ-029 Writing the value a register already holds SHALL still pulse cmd_valid.
REQ-030 End-to-end latency: control output changes 2 clocks after the LF stop-bit mid-sample.

Reset
REQ-031 On sys_rst high at a rising edge: receiver -> IDLE, parser -> P_OP, counters 0, synchronizer flops 1.
REQ-032 Reset values: rx_data 0x00, rx_valid 0, frame_err 0, cmd_valid 0, cmd_err 0, fir_en 0, lms_en 0, pmod_sel 0.
REQ-033 Reset mid-frame or mid-command SHALL discard the partial byte/command; no pulse SHALL be generated from it after reset release.

Verification
REQ-034 Send 0x55 at 434 clks/bit -> rx_valid single pulse, rx_data 0x55, frame_err 0.
REQ-035 Send "F1\n" then "P1\n" back-to-back, no idle -> two cmd_valid pulses, fir_en 1, pmod_sel 1, lms_en 0.
REQ-036 Send byte 0xA3 with stop bit low -> frame_err pulse, rx_valid 0, rx_data unchanged; mid-command (after "L1") -> cmd_err pulse, lms_en unchanged.
REQ-037 Send "LX\n" and "L1A" -> cmd_err pulse each, lms_en stays 0; following "L1\n" -> lms_en 1.
REQ-038 Send "F1", wait TIMEOUT+10 clocks -> cmd_err pulse; then "\n" -> no cmd_valid, fir_en unchanged.
REQ-039 Low glitch of 100 clocks on uart_rx -> no rx_valid, no frame_err; assert sys_rst during bit 4 of "F" -> all outputs at reset values, subsequent "F1\n" accepted normally.
